sccb_config_sequencer: RTL
==========================

# sccb_config_sequencer

Drives the OV7670 SCCB bus at power-up. Walks the camera register lookup table from the first configuration entry to the last, fetches each 16-bit entry (high byte register, low byte value), and sends it as a 3-phase SCCB write to the camera. Sits between the combinational configuration LUT and the camera's SIOC/SIOD pins, and reports busy/done/ack status to the top level.

## Interface
- CLK_FREQ_HZ, 25_000_000, system clock frequency
- SCCB_FREQ_HZ, 100_000, SIOC bit rate
- DEV_ADDR, 8'h42, SCCB write address (OV7670)
- LUT_FIRST, 2, first LUT index sent
- LUT_LAST, 167, last LUT index sent (inclusive)
- BOOT_DELAY, 25_000_000, idle cycles after reset before the first transaction
- RST_DELAY, 25_000, extra wait after any write to reg 8'h12 with data bit7 = 1
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; reruns the full table from IDLE or DONE
- lut_index  out  8  LUT address to the configuration table
- lut_data  in  16  combinational LUT output for lut_index; {reg, value}
- sioc  out  1  SCCB clock, push-pull
- siod_oe  out  1  1 = drive SIOD low; 0 = release (pull-up high)
- siod_i  in  1  SIOD pad input, sampled in ACK slots
- busy  out  1  high from the first cycle of BOOT until DONE is entered
- done  out  1  high while in DONE
- ack_err  out  1  sticky; set when any ACK slot samples 1; cleared on start/rst

## Operation
- Tick generator: a quarter-bit tick every Q = CLK_FREQ_HZ / (4·SCCB_FREQ_HZ) cycles, truncated (25 MHz/100 kHz gives Q = 62). All bus activity advances on ticks only.
- Each bit takes 4 quarters. In q0, sioc=0 and siod is updated. In q1 and q2, sioc=1; siod_i is sampled at the end of q2. In q3, sioc=0.
- Start condition: siod released, sioc=1 (1 quarter); siod driven low (1 quarter); sioc=0 (2 quarters).
- Stop condition: siod low, sioc=0 (1 quarter); sioc=1 (1 quarter); siod released (2 quarters).
- Frame: START, then DEV_ADDR, lut_data[15:8], lut_data[7:0], each MSB first and followed by a 9th don't-care/ACK slot with siod released, then STOP. Total 116 quarters.
- A 1 in any ACK slot sets ack_err. The transfer is not aborted.
- States:
  - IDLE: after start, clears ack_err and goes to BOOT.
  - BOOT: waits BOOT_DELAY cycles, then FETCH.
  - FETCH: latches lut_data into a 16-bit shift register, then START.
  - START, SEND (27-bit counter), STOP, in sequence.
  - GAP: 8 quarters of bus idle.
  - RSTWAIT: RST_DELAY cycles; entered instead of GAP when the latched reg is 8'h12 and data[7] = 1.
  - After GAP/RSTWAIT: if lut_index == LUT_LAST, go to DONE; otherwise increment lut_index and go to FETCH.
  - DONE: holds until start, which resets lut_index to LUT_FIRST and enters BOOT.
- After rst deassertion the FSM enters BOOT automatically; no start is required for the first run.
- Entries equal to 16'h0000 are valid writes (reg 00 = 00), not terminators.
- start is ignored while busy.

## Timing
- Reset values:
  - sioc=1, siod_oe=0, lut_index=LUT_FIRST, busy=0, done=0, ack_err=0.
  - State goes to BOOT on the first clk edge after rst falls. busy=1 from that edge.
- lut_data is sampled in the FETCH cycle, one clk after lut_index is updated. The LUT is combinational, so there is no further latency.
- Per-entry time is (116 + 8)·4·Q/4 = 124 quarters. At Q=62 this is 7688 cycles, about 307.5 µs.
- Total run: BOOT_DELAY + 166·124·Q cycles, plus RST_DELAY for each qualifying entry.
- done rises on the same edge busy falls.
- rst mid-frame: outputs return to reset values asynchronously, which releases the bus. The next run starts from LUT_FIRST.
- start in the same cycle as rst release is ignored; the auto-run proceeds.

## Structure
- Package sccb_pkg: state enum (IDLE, BOOT, FETCH, START, SEND, STOP, GAP, RSTWAIT, DONE), DEV_ADDR_OV7670 = 8'h42, QUARTERS_PER_FRAME = 116, GAP_QUARTERS = 8.
- Sub-module sccb_tick_gen: parameterised divider with enable. It outputs a one-cycle tick pulse and the 2-bit quarter index. It restarts at quarter 0 when enabled.

## Test plan
- Reset plus auto-run, BOOT_DELAY=10, Q=2, LUT model returning {index, ~index} → 166 frames. Frame 0 decodes to 42/02/FD. Last frame decodes to 42/A7/58. Then done=1, busy=0, lut_index=167.
- Bus-level decode with an SCCB monitor: start and stop edges occur only while sioc=1. siod changes only while sioc=0. 124 quarters elapse between start conditions.
- Entry 16'h1280 at LUT_FIRST → RSTWAIT lasts exactly RST_DELAY cycles before the second FETCH. Entry 16'h1214 → normal 8-quarter GAP.
- Slave model drives siod_i=1 in the second ACK slot of frame 5 → ack_err=1 from that sample, the sequence completes, and start clears ack_err.
- rst asserted mid-SEND of frame 3 → sioc=1 and siod_oe=0 immediately. After release, frame 0 is resent.
- start pulse while busy → no effect. start in DONE → busy on the next edge, lut_index=LUT_FIRST, and the full sequence repeats.

Source files
------------

// File: rtl/sccb_config_sequencer_pkg.sv
// rtl/sccb_config_sequencer_pkg.sv - shared types and constants for the SCCB configuration sequencer
// Purpose: FSM state encoding, OV7670 bus constants and the frame builder used by the sequencer.
package sccb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BOOT,
    S_FETCH,
    S_START,
    S_SEND,
    S_STOP,
    S_GAP,
    S_RSTWAIT,
    S_DONE
  } state_e;

  localparam logic [7:0] DEV_ADDR_OV7670    = 8'h42;
  localparam int         QUARTERS_PER_FRAME = 116;
  localparam int         GAP_QUARTERS       = 8;
  localparam int         FRAME_BITS         = 27;

  // Three bytes, each followed by a released (1) ACK slot; bit 26 goes out first.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] dev, input logic [15:0] entry);
    return {dev, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
  endfunction

endpackage

// File: rtl/sccb_config_sequencer_if.sv
// rtl/sccb_config_sequencer_if.sv - LUT, SCCB pad and status signals of the configuration sequencer
// Purpose: bundles everything except clk/rst.
//   start     : pulse, reruns the table from IDLE/DONE
//   lut_index : LUT address, lut_data : {reg, value} from the combinational LUT
//   sioc      : SCCB clock, siod_oe : 1 = pull SIOD low, siod_i : SIOD pad input
//   busy/done/ack_err : run status
// master = sequencer side, slave = LUT/pad/top-level side.
interface sccb_config_sequencer_if;
  logic        start;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic        sioc;
  logic        siod_oe;
  logic        siod_i;
  logic        busy;
  logic        done;
  logic        ack_err;

  modport master (
    input  start, lut_data, siod_i,
    output lut_index, sioc, siod_oe, busy, done, ack_err
  );

  modport slave (
    output start, lut_data, siod_i,
    input  lut_index, sioc, siod_oe, busy, done, ack_err
  );
endinterface

// File: rtl/sccb_config_sequencer_tick_gen.sv
// rtl/sccb_config_sequencer_tick_gen.sv - quarter-bit tick divider for the SCCB sequencer
// Purpose: pulses tick_o for one cycle every Q enabled cycles and counts quarters modulo 4.
//   clk, rst  : clock, async active-high reset
//   en_i      : run; while low the divider is held at cycle 0 of quarter 0
//   tick_o    : last cycle of the current quarter
//   quarter_o : index (0..3) of the current quarter
module sccb_tick_gen #(
  parameter int unsigned Q = 62
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic       tick_o,
  output logic [1:0] quarter_o
);

  localparam int unsigned CW = (Q > 1) ? $clog2(Q) : 1;

  logic [CW-1:0] cnt_q;
  logic [1:0]    quarter_q;

  assign tick_o    = en_i && (cnt_q == CW'(Q - 1));
  assign quarter_o = quarter_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else if (!en_i) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else if (tick_o) begin
      cnt_q     <= '0;
      quarter_q <= quarter_q + 2'd1;
    end else begin
      cnt_q     <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sccb_config_sequencer.sv
// rtl/sccb_config_sequencer.sv - power-up SCCB writer walking the OV7670 configuration LUT
// Purpose: after reset (or start from DONE) waits BOOT_DELAY cycles, then sends every LUT entry
// LUT_FIRST..LUT_LAST as a 3-phase SCCB write {DEV_ADDR, reg, value}.
//   clk, rst : clock, async active-high reset (releases the bus)
//   bus      : sccb_config_sequencer_if.master (start, LUT, SIOC/SIOD, busy/done/ack_err)
module sccb_config_sequencer
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 25_000_000,
  parameter int unsigned SCCB_FREQ_HZ = 100_000,
  parameter logic [7:0]  DEV_ADDR     = DEV_ADDR_OV7670,
  parameter logic [7:0]  LUT_FIRST    = 8'd2,
  parameter logic [7:0]  LUT_LAST     = 8'd167,
  parameter int unsigned BOOT_DELAY   = 25_000_000,
  parameter int unsigned RST_DELAY    = 25_000
) (
  input  logic                   clk,
  input  logic                   rst,
  sccb_config_sequencer_if.master bus
);

  localparam int unsigned Q_RAW = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  // FETCH shares the first cycle of quarter 0, so a quarter needs at least two cycles.
  localparam int unsigned Q     = (Q_RAW < 2) ? 2 : Q_RAW;

  state_e                  state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [4:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic                    rst_entry_q, rst_entry_d;
  logic [7:0]              index_q, index_d;
  logic                    ack_err_q, ack_err_d;
  logic                    sioc_q, sioc_d;
  logic                    siod_oe_q, siod_oe_d;
  logic                    tick_en, tick, ack_slot, last_entry;
  logic [1:0]              quarter;

  // The divider keeps running from FETCH through GAP so back-to-back frames stay 124 quarters apart.
  assign tick_en    = state_q inside {S_FETCH, S_START, S_SEND, S_STOP, S_GAP};
  assign ack_slot   = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);
  assign last_entry = (index_q == LUT_LAST);

  sccb_tick_gen #(.Q(Q)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en_i      (tick_en),
    .tick_o    (tick),
    .quarter_o (quarter)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    rst_entry_d = rst_entry_q;
    index_d     = index_q;
    ack_err_d   = ack_err_q;
    sioc_d      = 1'b1;
    siod_oe_d   = 1'b0;
    case (state_q)
      // Only reached from reset: the first run starts without a start pulse.
      S_IDLE: begin
        ack_err_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_BOOT;
      end
      S_BOOT: begin
        if (cnt_q + 32'd1 >= BOOT_DELAY) state_d = S_FETCH;
        else                             cnt_d   = cnt_q + 32'd1;
      end
      S_FETCH: begin
        frame_d     = build_frame(DEV_ADDR, bus.lut_data);
        rst_entry_d = (bus.lut_data[15:8] == 8'h12) && bus.lut_data[7];
        bit_d       = '0;
        state_d     = S_START;
      end
      S_START: begin
        sioc_d    = ~quarter[1];
        siod_oe_d = (quarter != 2'd0);
        if (tick && quarter == 2'd3) state_d = S_SEND;
      end
      S_SEND: begin
        sioc_d    = quarter[0] ^ quarter[1];
        siod_oe_d = ~frame_q[FRAME_BITS-1];
        if (tick && quarter == 2'd2 && ack_slot && bus.siod_i) ack_err_d = 1'b1;
        if (tick && quarter == 2'd3) begin
          frame_d = {frame_q[FRAME_BITS-2:0], 1'b1};
          if (bit_q == 5'(FRAME_BITS - 1)) state_d = S_STOP;
          else                             bit_d   = bit_q + 5'd1;
        end
      end
      S_STOP: begin
        sioc_d    = (quarter != 2'd0);
        siod_oe_d = ~quarter[1];
        if (tick && quarter == 2'd3) begin
          cnt_d   = '0;
          state_d = rst_entry_q ? S_RSTWAIT : S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (cnt_q == 32'(GAP_QUARTERS - 1)) begin
            state_d = last_entry ? S_DONE : S_FETCH;
            if (!last_entry) index_d = index_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      // Camera soft reset (COM7 bit7) needs settling time before the next write.
      S_RSTWAIT: begin
        if (cnt_q + 32'd1 >= RST_DELAY) begin
          state_d = last_entry ? S_DONE : S_FETCH;
          if (!last_entry) index_d = index_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          index_d   = LUT_FIRST;
          ack_err_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_BOOT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '1;
      rst_entry_q <= 1'b0;
      index_q     <= LUT_FIRST;
      ack_err_q   <= 1'b0;
      sioc_q      <= 1'b1;
      siod_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      rst_entry_q <= rst_entry_d;
      index_q     <= index_d;
      ack_err_q   <= ack_err_d;
      sioc_q      <= sioc_d;
      siod_oe_q   <= siod_oe_d;
    end
  end

  assign bus.lut_index = index_q;
  assign bus.sioc      = sioc_q;
  assign bus.siod_oe   = siod_oe_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.busy      = !(state_q inside {S_IDLE, S_DONE});
  assign bus.done      = (state_q == S_DONE);

endmodule
